generador_secuencia: RTL and testbench
======================================

// Module: generador_secuencia
//
// PURPOSE
//   Serial pattern transmitter: the driving end of the A/B serial-line sequence detectors.
//   - Accepts a parallel word through a valid/ready handshake.
//   - Shifts the word out MSB-first on line A, with B as the data-qualifier strobe.
//   - Holds each bit for a programmable number of clocks, then inserts an idle gap.
//   - Feeds detector FSMs on chip and drives their benches as a stimulus source.
//
// PARAMETERS
//   ANCHO  8  data word width in bits (>=1)
//   DIV    1  clocks per transmitted bit (>=1)
//   GAP    2  idle clocks after each frame before the next word is accepted (>=1)
//
// PORTS
//   clk              in   1      system clock, rising edge
//   rst              in   1      asynchronous reset, active-high
//   dato             in   ANCHO  word to transmit, sampled on acceptance
//   valido           in   1      word request
//   listo            out  1      ready; word accepted on a clk edge with valido&&listo
//   A                out  1      serial data line, MSB first
//   B                out  1      qualifier: 1 while a data bit is on A
//   fin              out  1      one-cycle pulse, first cycle after the last bit
//   estado_depurado  out  3      current FSM state (debug)
//
// BEHAVIOUR
//   Clock and reset
//   - One clock domain.
//   - rst is asynchronous and active-high: on assertion, all state clears immediately.
//   Reset values
//   - estado=REPOSO, shift register=0, bit and divider counters=0.
//   - A=0, B=0, fin=0, listo=1.
//   - valido is ignored while rst=1.
//   States (3-bit encoding)
//   - REPOSO=000: listo=1, A=0, B=0.
//     - valido=1 at an edge: capture dato, clear counters, go to DATOS.
//   - DATOS=001: listo=0, B=1, A=shift-register MSB.
//     - The divider counts 0..DIV-1; at DIV-1 it shifts left by one and increments the bit counter.
//     - After ANCHO bits, go to PAUSA.
//   - PAUSA=010: listo=0, A=0, B=0.
//     - fin=1 only in the first PAUSA cycle.
//     - Counts GAP cycles, then returns to REPOSO.
//   - Unused codes 011..111: next state REPOSO; all outputs as in REPOSO.
//   Outputs
//   - A, B and fin are registered (Moore); listo decodes from the state only.
//   - No combinational path from inputs to outputs.
//   Timing, with acceptance edge = cycle k
//   - Bit i (i=0 is the MSB) is on A during cycles k+1+i*DIV .. k+(i+1)*DIV.
//   - fin=1 in cycle k+1+ANCHO*DIV.
//   - listo=1 again in cycle k+1+ANCHO*DIV+GAP.
//   - Frame period = 1+ANCHO*DIV+GAP clocks.
//   Boundary conditions
//   - dato/valido changes while listo=0 are ignored; the captured word is unaffected.
//   - valido held high: the next word is accepted on the first edge where listo=1.
//     - Back-to-back frames are separated by exactly GAP idle cycles plus the acceptance cycle.
//   - Reset mid-frame aborts the frame: A=B=0 at once, the partial word is discarded, no resume.
//   - DIV=1: a new bit every clock, and the divider counter is constant 0.
//   - Counter widths: $clog2(ANCHO+1), $clog2(DIV+1), $clog2(GAP+1). Counters never wrap mid-frame.
//
// TESTING (ANCHO=8, GAP=2 unless noted; cycle 0 = acceptance edge)
//   1. Reset: assert rst mid-DATOS, between clock edges
//      -> A=0, B=0, listo=1, estado_depurado=000 before the next edge.
//   2. DIV=1, dato=8'hA5, valido for 1 cycle
//      -> A=1,0,1,0,0,1,0,1 in cycles 1..8; B=1 in cycles 1..8; fin=1 in cycle 9 only; listo=1 from cycle 11.
//   3. DIV=3, dato=8'h81
//      -> A=1 in cycles 1..3, A=0 in cycles 4..21, A=1 in cycles 22..24; B=1 in cycles 1..24; fin in cycle 25.
//   4. valido held at 1; dato=8'h0F at acceptance, changed to 8'hFF in cycle 3
//      -> the frame transmits 0F; FF is accepted at the cycle-11 edge; its bits appear from cycle 12.
//   5. Back-to-back 8'h00 then 8'hFF, DIV=1
//      -> A=0 in cycles 1..8, B=0 in cycles 9..11, then A=1 and B=1 in cycles 12..19.
//   6. Reset during bit 4 of 8'hC3, then send 8'h3C
//      -> the aborted frame leaves no trace; 3C is transmitted complete and correct; fin pulses exactly once.

Source files
------------

// File: rtl/generador_secuencia.sv
// Serial pattern transmitter: shifts a parallel word out MSB-first on A with B as data qualifier,
// each bit held DIV clocks, followed by a GAP-cycle idle pause with a one-cycle fin pulse.
module generador_secuencia #(
  parameter int unsigned ANCHO = 8,
  parameter int unsigned DIV   = 1,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] dato,
  input  logic             valido,
  output logic             listo,
  output logic             A,
  output logic             B,
  output logic             fin,
  output logic [2:0]       estado_depurado
);

  localparam int unsigned BW = $clog2(ANCHO + 1);
  localparam int unsigned DW = $clog2(DIV + 1);
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    REPOSO = 3'b000,
    DATOS  = 3'b001,
    PAUSA  = 3'b010
  } estado_e;

  estado_e          estado_q, estado_d;
  logic [ANCHO-1:0] shift_q, shift_d;
  logic [ANCHO-1:0] desplazado;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             fin_q, fin_d;

  // Outputs are computed from the next state so A shows the MSB right after acceptance.
  always_comb begin
    estado_d   = estado_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    div_d      = div_q;
    gap_d      = gap_q;
    a_d        = 1'b0;
    b_d        = 1'b0;
    fin_d      = 1'b0;
    desplazado = shift_q << 1;
    case (estado_q)
      REPOSO: begin
        if (valido) begin
          estado_d = DATOS;
          shift_d  = dato;
          bit_d    = '0;
          div_d    = '0;
          a_d      = dato[ANCHO-1];
          b_d      = 1'b1;
        end
      end
      DATOS: begin
        a_d = shift_q[ANCHO-1];
        b_d = 1'b1;
        if (div_q == DW'(DIV - 1)) begin
          div_d   = '0;
          shift_d = desplazado;
          bit_d   = bit_q + BW'(1);
          a_d     = desplazado[ANCHO-1];
          if (bit_q == BW'(ANCHO - 1)) begin
            estado_d = PAUSA;
            gap_d    = '0;
            a_d      = 1'b0;
            b_d      = 1'b0;
            fin_d    = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      PAUSA: begin
        if (gap_q == GW'(GAP - 1)) begin
          estado_d = REPOSO;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= REPOSO;
      shift_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      gap_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fin_q    <= fin_d;
    end
  end

  // Unused encodings behave like REPOSO, so only the two busy states drop listo.
  assign listo           = !((estado_q == DATOS) || (estado_q == PAUSA));
  assign A               = a_q;
  assign B               = b_q;
  assign fin             = fin_q;
  assign estado_depurado = estado_q;

endmodule

// File: tb/tb_generador_secuencia.sv
// Bench for generador_secuencia: two instances (DIV=1 and DIV=3) with a frame-level model and
// a scoreboard that compares each transmitted frame when fin pulses.
`timescale 1ns/1ps
module tb_generador_secuencia;

  localparam int unsigned ANCHO = 8;
  localparam int unsigned GAP   = 2;

  typedef struct {
    logic [7:0] w;
    int         k;
  } trama_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nombre, input int div, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s div=%0d got=%0h expected=%0h t=%0t", nombre, div, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int unsigned DV = (g == 0) ? 1 : 3;
    localparam int          ND = int'(ANCHO * DV);

    logic       rst    = 1'b1;
    logic       valido = 1'b0;
    logic [7:0] dato   = '0;
    logic       listo, a, b, fin;
    logic [2:0] est;

    int         cyc   = 0;
    int         libre = 0;
    int         acc_n = 0;
    trama_t     cola[$];
    trama_t     t;
    logic [31:0] vec = '0;
    logic [31:0] ev;
    int         ns = 0;
    logic       done = 1'b0;

    generador_secuencia #(.ANCHO(ANCHO), .DIV(DV), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .dato(dato), .valido(valido), .listo(listo),
      .A(a), .B(b), .fin(fin), .estado_depurado(est)
    );

    // Model: a word is taken at an edge when requested and the previous frame period has elapsed.
    initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst && valido && cyc >= libre) begin
        cola.push_back('{dato, cyc});
        libre = cyc + 1 + ND + int'(GAP);
        acc_n++;
      end
    end

    // Monitor: collect qualified bits, compare the whole frame when fin pulses.
    initial forever begin
      @(negedge clk);
      if (rst) begin
        ns  = 0;
        vec = '0;
        chk("rst_A", DV, 32'(a), 32'(0));
        chk("rst_B", DV, 32'(b), 32'(0));
        chk("rst_fin", DV, 32'(fin), 32'(0));
        chk("rst_listo", DV, 32'(listo), 32'(1));
        chk("rst_estado", DV, 32'(est), 32'(0));
      end else begin
        chk("listo", DV, 32'(listo), 32'(cyc + 1 >= libre));
        if (b) begin
          vec = {vec[30:0], a};
          ns++;
        end else begin
          chk("A_idle", DV, 32'(a), 32'(0));
        end
        if (fin) begin
          if (cola.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fin_sin_trama div=%0d got=fin expected=no_fin t=%0t", DV, $time);
          end else begin
            t  = cola.pop_front();
            ev = '0;
            for (int s = 0; s < ND; s++) ev = {ev[30:0], t.w[7 - s / int'(DV)]};
            chk("fin_ciclo", DV, 32'(cyc), 32'(t.k + ND));
            chk("num_bits", DV, 32'(ns), 32'(ND));
            chk("trama", DV, vec, ev);
          end
          ns  = 0;
          vec = '0;
        end
      end
    end

    task automatic reset_pulse();
      @(negedge clk);
      #1 rst = 1'b1;
      cola.delete();
      libre = 0;
      #1;
      chk("async_A", DV, 32'(a), 32'(0));
      chk("async_B", DV, 32'(b), 32'(0));
      chk("async_listo", DV, 32'(listo), 32'(1));
      chk("async_estado", DV, 32'(est), 32'(0));
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
    endtask

    task automatic esperar_acc(input int objetivo);
      for (int i = 0; i < 200 && acc_n < objetivo; i++) @(negedge clk);
      chk("acept_timeout", DV, 32'(acc_n >= objetivo), 32'(1));
    endtask

    task automatic enviar(input logic [7:0] w);
      int n0;
      n0 = acc_n;
      @(negedge clk);
      dato   = w;
      valido = 1'b1;
      esperar_acc(n0 + 1);
      valido = 1'b0;
    endtask

    task automatic esperar_fin();
      for (int i = 0; i < 300 && (cola.size() != 0 || cyc + 1 < libre); i++) @(negedge clk);
      chk("drenado", DV, 32'(cola.size()), 32'(0));
    endtask

    initial begin
      int n0;
      reset_pulse();
      enviar(8'hA5);
      esperar_fin();
      enviar(8'h81);
      esperar_fin();
      // valido held: word changes mid-frame, next word taken when ready again
      n0 = acc_n;
      @(negedge clk);
      dato   = 8'h0F;
      valido = 1'b1;
      esperar_acc(n0 + 1);
      repeat (2) @(negedge clk);
      dato = 8'hFF;
      esperar_acc(n0 + 2);
      valido = 1'b0;
      esperar_fin();
      // back-to-back 00 then FF
      n0 = acc_n;
      @(negedge clk);
      dato   = 8'h00;
      valido = 1'b1;
      esperar_acc(n0 + 1);
      dato = 8'hFF;
      esperar_acc(n0 + 2);
      valido = 1'b0;
      esperar_fin();
      // abort C3 around bit 4, then send 3C
      enviar(8'hC3);
      for (int i = 0; i < 50 && !b; i++) @(negedge clk);
      repeat (4 * DV - 1) @(negedge clk);
      reset_pulse();
      enviar(8'h3C);
      esperar_fin();
      // random traffic with occasional resets
      repeat (300) begin
        @(negedge clk);
        valido = 1'($urandom_range(0, 1));
        dato   = 8'($urandom);
        if ($urandom_range(0, 99) == 0) begin
          valido = 1'b0;
          reset_pulse();
        end
      end
      @(negedge clk);
      valido = 1'b0;
      esperar_fin();
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(gi[0].done && gi[1].done); i++) @(negedge clk);
    if (!(gi[0].done && gi[1].done)) begin
      checks++;
      errors++;
      $display("FAIL global_timeout got=not_done expected=done");
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
